// File: rtl/usr_arb_seq.sv
// ----------------------------------------------------------------------------
// usr_arb_seq
//
// Two-requester round-robin arbiter in front of a WIDTH-bit universal shift
// register. The winning requester's word is parallel-loaded into the register
// and shifted out serially, LSB-first (dir=0) or MSB-first (dir=1). The owner
// then receives a one-cycle done pulse.
//
// Ports
//    clk_i        rising-edge clock
//    rst_ni       synchronous reset, active-low
//    req_i[1:0]   per-requester transfer request
//    data0_i      parallel word from requester 0
//    data1_i      parallel word from requester 1
//    dir0_i       shift direction for requester 0 (0 = LSB first, 1 = MSB first)
//    dir1_i       shift direction for requester 1
//    gnt_o[1:0]   one-hot grant, held from LOAD through SHIFT
//    done_o[1:0]  one-cycle completion pulse to the owning requester
//    busy_o       high in every state except IDLE
//    sel_o[1:0]   register mode: 0 hold, 1 shift right, 2 shift left, 3 load
//    q_o          register contents
//    sout_o       serial data bit
//    sout_vld_o   sout_o carries a valid bit
// ----------------------------------------------------------------------------
module usr_arb_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [1:0]       req_i,
   input  logic [WIDTH-1:0] data0_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic             dir0_i,
   input  logic             dir1_i,
   output logic [1:0]       gnt_o,
   output logic [1:0]       done_o,
   output logic             busy_o,
   output logic [1:0]       sel_o,
   output logic [WIDTH-1:0] q_o,
   output logic             sout_o,
   output logic             sout_vld_o
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] SEL_HOLD  = 2'd0;
   localparam logic [1:0] SEL_RIGHT = 2'd1;
   localparam logic [1:0] SEL_LEFT  = 2'd2;
   localparam logic [1:0] SEL_LOAD  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] q_q;
   logic [CW-1:0]    cnt_q;
   logic             ptr_q;    // requester favoured on a tie
   logic             win_q;    // owner of the transfer in flight
   logic             dir_q;    // latched direction of the owner
   logic [1:0]       gnt_q;
   logic [1:0]       done_q;
   logic             busy_q;
   logic [1:0]       sel_q;
   logic             vld_q;

   logic             win_d;
   logic             dir_d;
   logic [WIDTH-1:0] q_shift_d;

   // Arbitration: a lone request wins outright, a tie goes to the pointer.
   always_comb begin
      win_d = ptr_q;
      if (req_i == 2'b01) begin
         win_d = 1'b0;
      end else if (req_i == 2'b10) begin
         win_d = 1'b1;
      end
      dir_d = win_d ? dir1_i : dir0_i;
   end

   // One-place shift with zero fill in the latched direction.
   always_comb begin
      if (dir_q) begin
         q_shift_d = {q_q[WIDTH-2:0], 1'b0};
      end else begin
         q_shift_d = {1'b0, q_q[WIDTH-1:1]};
      end
   end

   // State and all Moore outputs are registered together: each branch sets
   // the output registers to the values belonging to the state being entered.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         q_q     <= '0;
         cnt_q   <= '0;
         ptr_q   <= 1'b0;
         win_q   <= 1'b0;
         dir_q   <= 1'b0;
         gnt_q   <= 2'b00;
         done_q  <= 2'b00;
         busy_q  <= 1'b0;
         sel_q   <= SEL_HOLD;
         vld_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (|req_i) begin
                  state_q <= S_LOAD;
                  win_q   <= win_d;
                  dir_q   <= dir_d;
                  gnt_q   <= win_d ? 2'b10 : 2'b01;
                  busy_q  <= 1'b1;
                  sel_q   <= SEL_LOAD;
               end
            end
            S_LOAD: begin
               // Requester guarantees its word is stable until it sees gnt,
               // so sampling at the closing LOAD edge is safe.
               q_q     <= win_q ? data1_i : data0_i;
               cnt_q   <= '0;
               state_q <= S_SHIFT;
               sel_q   <= dir_q ? SEL_LEFT : SEL_RIGHT;
               vld_q   <= 1'b1;
            end
            S_SHIFT: begin
               q_q <= q_shift_d;
               if (cnt_q == CNT_LAST) begin
                  // Counter is held here rather than wrapping.
                  state_q <= S_DONE;
                  gnt_q   <= 2'b00;
                  done_q  <= win_q ? 2'b10 : 2'b01;
                  sel_q   <= SEL_HOLD;
                  vld_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DONE: begin
               ptr_q   <= ~win_q;
               state_q <= S_IDLE;
               done_q  <= 2'b00;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt_o      = gnt_q;
   assign done_o     = done_q;
   assign busy_o     = busy_q;
   assign sel_o      = sel_q;
   assign q_o        = q_q;
   assign sout_vld_o = vld_q;
   // Outgoing bit is whichever end of the register leaves on the next shift.
   assign sout_o     = vld_q & (dir_q ? q_q[WIDTH-1] : q_q[0]);

endmodule
